// File: rtl/mem_arbiter_if.sv
// Bus bundles for the memory arbiter: requester-side channel bus and downstream memory bus.
// On each bundle the master drives requests and the slave drives completions.
interface mem_arbiter_ch_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]                 ch_read;
  logic [NUM_CH-1:0]                 ch_write;
  logic [NUM_CH-1:0][ADDR_W-1:0]     ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0]     ch_wdata;
  logic [NUM_CH-1:0][DATA_W/8-1:0]   ch_mbe;
  logic [DATA_W-1:0]                 ch_rdata;
  logic [NUM_CH-1:0]                 ch_resp;

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, ch_mbe,
    input  ch_rdata, ch_resp
  );
  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, ch_mbe,
    output ch_rdata, ch_resp
  );
endinterface

interface mem_arbiter_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_mbe;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
    input  mem_rdata, mem_resp
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of a single memory port; one transaction in flight,
// round-robin or fixed-priority grant, IDLE -> BUSY -> DONE handshake.
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_arbiter_ch_if.slave   ch,
  mem_arbiter_mem_if.master mem
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   mbe_q, mbe_d;

  logic [NUM_CH-1:0]     req;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      sel_idx;
  logic                  sel_found;
  logic                  mem_read_o, mem_write_o;
  logic [NUM_CH-1:0]     ch_resp_o;
  logic [DATA_W-1:0]     ch_rdata_o;

  // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req       = ch.ch_read | ch.ch_write;
    cand      = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = PTR_W'(((RR_MODE != 0 ? int'(ptr_q) : 0) + k) % NUM_CH);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mbe_d       = mbe_q;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    ch_resp_o   = '0;
    ch_rdata_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          grant_d = sel_idx;
          write_d = ch.ch_write[sel_idx];
          addr_d  = ch.ch_addr[sel_idx];
          wdata_d = ch.ch_wdata[sel_idx];
          mbe_d   = ch.ch_mbe[sel_idx];
          if (RR_MODE != 0) begin
            ptr_d = PTR_W'((int'(sel_idx) + 1) % NUM_CH);
          end
        end
      end
      BUSY: begin
        // A read+write request was latched as a write, so write_q alone picks the strobe.
        mem_read_o  = ~write_q;
        mem_write_o = write_q;
        if (mem.mem_resp) begin
          ch_resp_o[grant_q] = 1'b1;
          ch_rdata_o         = mem.mem_rdata;
          state_d            = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: all control and latched fields are reset so the downstream bus reads 0 after reset.
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
    end
  end

  assign mem.mem_read  = mem_read_o;
  assign mem.mem_write = mem_write_o;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_mbe   = mbe_q;
  assign ch.ch_resp    = ch_resp_o;
  assign ch.ch_rdata   = ch_rdata_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a 2-channel round-robin arbiter and a 4-channel fixed-priority arbiter.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_ch_if  #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) rr_ch ();
  mem_arbiter_mem_if #(.ADDR_W(32), .DATA_W(32))             rr_mem ();
  mem_arbiter_ch_if  #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) fp_ch ();
  mem_arbiter_mem_if #(.ADDR_W(32), .DATA_W(32))             fp_mem ();

  mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .ch(rr_ch.slave), .mem(rr_mem.master)
  );
  mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .ch(fp_ch.slave), .mem(fp_mem.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Accessors so one scenario task can target either instance (f=1 selects the 4-channel one).
  function automatic logic strobe(bit f);
    return f ? (fp_mem.mem_read | fp_mem.mem_write) : (rr_mem.mem_read | rr_mem.mem_write);
  endfunction
  function automatic logic [3:0] resp(bit f);
    return f ? fp_ch.ch_resp : {2'b00, rr_ch.ch_resp};
  endfunction
  function automatic logic [31:0] rdata(bit f);
    return f ? fp_ch.ch_rdata : rr_ch.ch_rdata;
  endfunction
  function automatic logic [31:0] maddr(bit f);
    return f ? fp_mem.mem_addr : rr_mem.mem_addr;
  endfunction

  task automatic set_mem(bit f, logic r, logic [31:0] d);
    if (f) begin fp_mem.mem_resp = r; fp_mem.mem_rdata = d; end
    else   begin rr_mem.mem_resp = r; rr_mem.mem_rdata = d; end
  endtask

  task automatic mask_reqs(bit f, logic [3:0] keep);
    if (f) begin
      fp_ch.ch_read  = fp_ch.ch_read & keep;
      fp_ch.ch_write = fp_ch.ch_write & keep;
    end else begin
      rr_ch.ch_read  = rr_ch.ch_read & keep[1:0];
      rr_ch.ch_write = rr_ch.ch_write & keep[1:0];
    end
  endtask

  task automatic clear_inputs();
    rr_ch.ch_read = '0; rr_ch.ch_write = '0; rr_ch.ch_addr = '0;
    rr_ch.ch_wdata = '0; rr_ch.ch_mbe = '0;
    fp_ch.ch_read = '0; fp_ch.ch_write = '0; fp_ch.ch_addr = '0;
    fp_ch.ch_wdata = '0; fp_ch.ch_mbe = '0;
    set_mem(1'b0, 1'b0, 32'h0);
    set_mem(1'b1, 1'b0, 32'h0);
  endtask

  // Wait (bounded) for a downstream strobe; returns at negedge+1 of the first BUSY cycle.
  task automatic wait_strobe(bit f, string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!strobe(f) && n < 6) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (strobe(f) !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_strobe: no downstream strobe within 6 cycles", name);
    end
  endtask

  // Response cycle then the DONE cycle; requests outside `keep` are dropped during DONE.
  task automatic respond(bit f, logic [3:0] exp_resp, logic [31:0] d, logic [3:0] keep, string name);
    set_mem(f, 1'b1, d);
    #1;
    n_cmp++;
    if (resp(f) !== exp_resp) begin
      n_bad++;
      $display("FAIL %s_resp: ch_resp=%b expected %b", name, resp(f), exp_resp);
    end
    n_cmp++;
    if (rdata(f) !== d) begin
      n_bad++;
      $display("FAIL %s_rdata: ch_rdata=%h expected %h", name, rdata(f), d);
    end
    @(negedge clk);
    set_mem(f, 1'b0, 32'h0);
    mask_reqs(f, keep);
    #1;
    n_cmp++;
    if (strobe(f) !== 1'b0 || resp(f) !== 4'b0) begin
      n_bad++;
      $display("FAIL %s_done: strobe=%b ch_resp=%b expected 0 and 0000", name, strobe(f), resp(f));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    for (int f = 0; f < 2; f++) begin
      n_cmp++;
      if (strobe(f[0]) !== 1'b0 || resp(f[0]) !== 4'b0 || rdata(f[0]) !== 32'h0 || maddr(f[0]) !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: strobe=%b resp=%b rdata=%h addr=%h expected all 0",
                 f, strobe(f[0]), resp(f[0]), rdata(f[0]), maddr(f[0]));
      end
    end
    n_cmp++;
    if (rr_mem.mem_wdata !== 32'h0 || rr_mem.mem_mbe !== 4'h0 || fp_mem.mem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_fields: wdata=%h mbe=%h expected 0", rr_mem.mem_wdata, rr_mem.mem_mbe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (strobe(1'b0) !== 1'b0 || strobe(1'b1) !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_idle: strobes=%b%b expected 00", strobe(1'b0), strobe(1'b1));
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    rr_ch.ch_addr[0] = 32'h0000_0060;
    rr_ch.ch_read    = 2'b01;
    @(negedge clk); #1;
    n_cmp++;
    if (rr_mem.mem_read !== 1'b1 || rr_mem.mem_write !== 1'b0 || rr_mem.mem_addr !== 32'h60) begin
      n_bad++;
      $display("FAIL single_read_strobe: read=%b write=%b addr=%h expected 1 0 00000060",
               rr_mem.mem_read, rr_mem.mem_write, rr_mem.mem_addr);
    end
    n_cmp++;
    if (rr_ch.ch_resp !== 2'b00 || rr_ch.ch_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL single_read_wait: ch_resp=%b ch_rdata=%h expected 00 0", rr_ch.ch_resp, rr_ch.ch_rdata);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_cmp++;
    if (rr_mem.mem_read !== 1'b1 || rr_mem.mem_addr !== 32'h60) begin
      n_bad++;
      $display("FAIL single_read_hold: read=%b addr=%h expected 1 00000060", rr_mem.mem_read, rr_mem.mem_addr);
    end
    respond(1'b0, 4'b0001, 32'hDEAD_BEEF, 4'b0000, "single_read");
  endtask

  task automatic test_rr_contention();
    logic [31:0] exp_addr;
    do_reset();
    rr_ch.ch_addr[0] = 32'h100;
    rr_ch.ch_addr[1] = 32'h200;
    rr_ch.ch_read    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
      wait_strobe(1'b0, "rr");
      n_cmp++;
      if (rr_mem.mem_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL rr_grant%0d: mem_addr=%h expected %h", i, rr_mem.mem_addr, exp_addr);
      end
      respond(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0010, 32'h5000 + i,
              (i == 3) ? 4'b0000 : 4'b0011, "rr");
    end
  endtask

  task automatic test_write_hold();
    rr_ch.ch_addr[1]  = 32'h80;
    rr_ch.ch_wdata[1] = 32'h1234_5678;
    rr_ch.ch_mbe[1]   = 4'b0110;
    rr_ch.ch_write    = 2'b10;
    wait_strobe(1'b0, "write");
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++;
      if (rr_mem.mem_write !== 1'b1 || rr_mem.mem_read !== 1'b0 || rr_mem.mem_addr !== 32'h80 ||
          rr_mem.mem_wdata !== 32'h1234_5678 || rr_mem.mem_mbe !== 4'b0110) begin
        n_bad++;
        $display("FAIL write_fields%0d: wr=%b rd=%b addr=%h data=%h mbe=%b expected 1 0 00000080 12345678 0110",
                 pass, rr_mem.mem_write, rr_mem.mem_read, rr_mem.mem_addr, rr_mem.mem_wdata, rr_mem.mem_mbe);
      end
      rr_ch.ch_addr[1]  = 32'hFFF0;
      rr_ch.ch_wdata[1] = 32'h0;
      rr_ch.ch_mbe[1]   = 4'b1111;
      @(negedge clk); #1;
    end
    respond(1'b0, 4'b0010, 32'hA5A5_0000, 4'b0000, "write");
  endtask

  task automatic test_rw_both();
    rr_ch.ch_addr[0] = 32'h44;
    rr_ch.ch_read    = 2'b01;
    rr_ch.ch_write   = 2'b01;
    wait_strobe(1'b0, "rw_both");
    n_cmp++;
    if (rr_mem.mem_write !== 1'b1 || rr_mem.mem_read !== 1'b0 || rr_mem.mem_addr !== 32'h44) begin
      n_bad++;
      $display("FAIL rw_both_is_write: wr=%b rd=%b addr=%h expected 1 0 00000044",
               rr_mem.mem_write, rr_mem.mem_read, rr_mem.mem_addr);
    end
    respond(1'b0, 4'b0001, 32'h0, 4'b0000, "rw_both");
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 4; i++) fp_ch.ch_addr[i] = 32'h10 + i;
    fp_ch.ch_read = 4'b1010;
    wait_strobe(1'b1, "fp_a");
    n_cmp++;
    if (fp_mem.mem_addr !== 32'h11) begin
      n_bad++;
      $display("FAIL fp_first: mem_addr=%h expected 00000011", fp_mem.mem_addr);
    end
    respond(1'b1, 4'b0010, 32'h11, 4'b1000, "fp_a");
    wait_strobe(1'b1, "fp_b");
    n_cmp++;
    if (fp_mem.mem_addr !== 32'h13) begin
      n_bad++;
      $display("FAIL fp_second: mem_addr=%h expected 00000013", fp_mem.mem_addr);
    end
    respond(1'b1, 4'b1000, 32'h13, 4'b1000, "fp_b");
    fp_ch.ch_read[0] = 1'b1;
    wait_strobe(1'b1, "fp_c");
    n_cmp++;
    if (fp_mem.mem_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL fp_ch0_wins: mem_addr=%h expected 00000010", fp_mem.mem_addr);
    end
    respond(1'b1, 4'b0001, 32'h10, 4'b1000, "fp_c");
    wait_strobe(1'b1, "fp_d");
    n_cmp++;
    if (fp_mem.mem_addr !== 32'h13) begin
      n_bad++;
      $display("FAIL fp_ch3_pending: mem_addr=%h expected 00000013", fp_mem.mem_addr);
    end
    respond(1'b1, 4'b1000, 32'h33, 4'b0000, "fp_d");
  endtask

  task automatic test_reset_mid_busy();
    rr_ch.ch_addr[0] = 32'h100;
    rr_ch.ch_addr[1] = 32'h200;
    rr_ch.ch_read    = 2'b01;
    wait_strobe(1'b0, "abort");
    @(negedge clk);
    rst_n         = 1'b0;
    rr_ch.ch_read = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    set_mem(1'b0, 1'b1, 32'hCAFE_F00D);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (rr_ch.ch_resp !== 2'b00 || rr_ch.ch_rdata !== 32'h0 || strobe(1'b0) !== 1'b0 ||
          rr_mem.mem_addr !== 32'h0) begin
        n_bad++;
        $display("FAIL abort_no_resp%0d: resp=%b rdata=%h strobe=%b addr=%h expected 00 0 0 0",
                 i, rr_ch.ch_resp, rr_ch.ch_rdata, strobe(1'b0), rr_mem.mem_addr);
      end
      @(negedge clk);
    end
    set_mem(1'b0, 1'b0, 32'h0);
    rr_ch.ch_read = 2'b11;
    wait_strobe(1'b0, "ptr_restart");
    n_cmp++;
    if (rr_mem.mem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL ptr_restart: mem_addr=%h expected 00000100", rr_mem.mem_addr);
    end
    respond(1'b0, 4'b0001, 32'h1, 4'b0010, "ptr_restart");
    wait_strobe(1'b0, "ptr_next");
    n_cmp++;
    if (rr_mem.mem_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL ptr_next: mem_addr=%h expected 00000200", rr_mem.mem_addr);
    end
    respond(1'b0, 4'b0010, 32'h2, 4'b0000, "ptr_next");
  endtask

  task automatic test_spurious_resp();
    @(negedge clk); #1;
    set_mem(1'b0, 1'b1, 32'h1111_2222);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (rr_ch.ch_resp !== 2'b00 || rr_ch.ch_rdata !== 32'h0 || strobe(1'b0) !== 1'b0) begin
        n_bad++;
        $display("FAIL spurious%0d: resp=%b rdata=%h strobe=%b expected 00 0 0",
                 i, rr_ch.ch_resp, rr_ch.ch_rdata, strobe(1'b0));
      end
      @(negedge clk);
    end
    set_mem(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_contention();
    test_write_hold();
    test_rw_both();
    test_fixed_priority();
    test_reset_mid_busy();
    test_spurious_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 32, address width in bits.
REQ-003 Parameter DATA_W, default 32, data width in bits, multiple of 8.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-007 ch_read  input  NUM_CH  per-channel read request, held until that channel's ch_resp.
REQ-008 ch_write  input  NUM_CH  per-channel write request, held until that channel's ch_resp.
REQ-009 ch_addr  input  NUM_CH x ADDR_W  per-channel address.
REQ-010 ch_wdata  input  NUM_CH x DATA_W  per-channel write data.
REQ-011 ch_mbe  input  NUM_CH x DATA_W/8  per-channel byte enables.
REQ-012 ch_rdata  output  DATA_W  read data, shared by all channels, valid only with ch_resp.
REQ-013 ch_resp  output  NUM_CH  one-hot per-channel completion pulse.
REQ-014 mem_read, mem_write  output  1 each  downstream request strobes.
REQ-015 mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W;  mem_mbe  output  DATA_W/8  downstream request fields.
REQ-016 mem_rdata  input  DATA_W;  mem_resp  input  1  downstream read data and completion.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-018 In IDLE, if any channel requests (read or write), the arbiter SHALL select channel g on the clock edge, latch ch_addr[g], ch_wdata[g], ch_mbe[g] and the operation, and go to BUSY.
REQ-019 If RR_MODE=1, g SHALL be the first requesting channel at or after the priority pointer, wrapping modulo NUM_CH; if RR_MODE=0, g SHALL be the lowest-numbered requesting channel.
REQ-020 If RR_MODE=1, the pointer SHALL update to (g+1) mod NUM_CH when g is granted, and SHALL wrap from NUM_CH-1 to 0.
REQ-021 In BUSY, mem_read or mem_write SHALL be driven from the latched operation, with the latched address, data and mbe, held stable until mem_resp.
REQ-022 Later changes on the granted channel's ch_* inputs SHALL NOT affect the downstream request.
REQ-023 In BUSY, when mem_resp=1 in a cycle, the arbiter SHALL, in that same cycle (combinationally), assert ch_resp[g]=1 and drive ch_rdata=mem_rdata, and go to DONE on the next edge.
REQ-024 In DONE, the arbiter SHALL drive mem_read=mem_write=0 and ch_resp=0 for exactly one cycle, then go to IDLE.
- Purpose: lets the served requester drop its request.
REQ-025 Latency: request seen at edge E -> mem strobe from E+1. Response cycle R -> next grant no earlier than edge R+2.
REQ-026 If ch_read[i] and ch_write[i] are both asserted, the arbiter SHALL treat the request as a write.
REQ-027 mem_resp while in IDLE or DONE SHALL be ignored: no ch_resp and no state change.
REQ-028 ch_resp SHALL never have more than one bit set, and only the granted channel's bit.
REQ-029 Ungranted requesters SHALL see ch_resp=0 and SHALL remain pending without loss.
REQ-030 Outside a ch_resp cycle, ch_rdata SHALL be 0.

Reset
REQ-031 With rst=0 at a clock edge, the arbiter SHALL enter IDLE and clear the pointer to 0 and the latched fields to 0, from any state including BUSY.
REQ-032 During and after reset: mem_read=mem_write=0, mem_addr=mem_wdata=mem_mbe=0, ch_resp=0, ch_rdata=0.
REQ-033 A transaction aborted by reset SHALL NOT produce ch_resp, even if mem_resp arrives afterwards.

Verification
REQ-034 Single read: ch_read[0]=1, addr 0x0000_0060; memory returns 0xDEAD_BEEF after 3 cycles -> mem_read high with mem_addr 0x60 from E+1; ch_resp=2'b01 and ch_rdata=0xDEAD_BEEF in the response cycle.
REQ-035 RR contention (NUM_CH=2): both channels hold reads continuously -> grants alternate 0,1,0,1; each grant is separated from the previous response by one DONE cycle.
REQ-036 Fixed priority (RR_MODE=0, NUM_CH=4): channels 1 and 3 request -> 1 is served first, then 3; then 0 and 3 request together -> 0 is served.
REQ-037 Write with mbe 4'b0110 and wdata 0x1234_5678 on ch1; the requester changes addr mid-BUSY -> downstream still sees the original addr, mbe 4'b0110 and data; only ch_resp[1] pulses.
REQ-038 Reset mid-BUSY: rst=0 for one edge, then mem_resp=1 -> no ch_resp, state IDLE, and the pointer restarts at 0.
REQ-039 Spurious mem_resp in IDLE -> no ch_resp and no downstream strobe.
